// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: widths, sum type and saturating add shared by the pixel summer and the int-to-float converter wrapper.
package pixel_stream_pkg;
    localparam int PIX_DATA_W = 8;
    localparam int PIX_SUM_W  = 21;

    typedef logic [PIX_SUM_W-1:0] pix_sum_t;

    // Returns {ovf, clamped sum}; clamps to all-ones instead of wrapping.
    function automatic logic [PIX_SUM_W:0] sat_add(input pix_sum_t acc, input logic [PIX_DATA_W-1:0] data);
        logic [PIX_SUM_W:0] s;
        s = {1'b0, acc} + (PIX_SUM_W + 1)'(data);
        return {s[PIX_SUM_W], s[PIX_SUM_W] ? {PIX_SUM_W{1'b1}} : s[PIX_SUM_W-1:0]};
    endfunction
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: single-entry valid/ready holding register; data holds its value after it is consumed.
module stream_out_reg #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         free
);
    assign free = !valid | ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pixel_group_summer.sv
// pixel_group_summer: sums unsigned pixel samples into saturating group sums, closing a group on eop or GROUP_LEN samples.
module pixel_group_summer
    import pixel_stream_pkg::*;
#(
    parameter int DATA_W    = PIX_DATA_W,
    parameter int SUM_W     = PIX_SUM_W,
    parameter int GROUP_LEN = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snk_valid,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_eop,
    output logic              snk_ready,
    output logic              src_valid,
    output logic [SUM_W-1:0]  src_data,
    output logic              src_sat,
    input  logic              src_ready
);
    localparam int CNT_W = GROUP_LEN > 1 ? $clog2(GROUP_LEN) : 1;

    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat_acc;
    logic             free;
    logic             accept;
    logic             last;
    logic [SUM_W:0]   sum_w;
    logic             ovf;
    logic [SUM_W-1:0] sum;

    assign snk_ready = free & !rst;
    assign accept    = snk_valid & snk_ready;
    assign last      = snk_eop | (cnt == CNT_W'(GROUP_LEN - 1));
    // acc never exceeds the max, so the carry bit alone flags overflow.
    assign sum_w     = {1'b0, acc} + (SUM_W + 1)'(snk_data);
    assign ovf       = sum_w[SUM_W];
    assign sum       = ovf ? '1 : sum_w[SUM_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            sat_acc <= 1'b0;
        end else if (accept) begin
            acc     <= last ? '0 : sum;
            cnt     <= last ? '0 : cnt + 1'b1;
            sat_acc <= last ? 1'b0 : sat_acc | ovf;
        end
    end

    stream_out_reg #(.W(SUM_W + 1)) u_out (
        .clk   (clk),
        .rst   (rst),
        .load  (accept & last),
        .din   ({sat_acc | ovf, sum}),
        .ready (src_ready),
        .valid (src_valid),
        .dout  ({src_sat, src_data}),
        .free  (free)
    );
endmodule
